smpl_seq_queue: RTL

Stereo circular sample queue feeding the band FIR filters. Stores incoming 16-bit left/right audio samples and, on each new sample once primed, replays the most recent TAPS samples, oldest first, one per clock, while asserting `sequencing`. It is the producing end of the `seq`/`lft_in`/`rght_in` interface consumed by every FIR band block. Its output alignment matches the FIR's one-cycle synchronous coefficient-ROM latency.

---
 rtl/smpl_seq_pkg.sv | 10 +
 rtl/dp_ram_stereo.sv | 25 ++
 rtl/smpl_seq_queue.sv | 88 ++++++++
 3 files changed

// File: rtl/smpl_seq_pkg.sv
// smpl_seq_pkg: shared types and default sizing for the stereo sample queue.
package smpl_seq_pkg;
    typedef enum logic [1:0] {FILL, WAIT, SEQ} state_t;
    localparam int TAPS_DEF   = 1021;
    localparam int ADDR_W_DEF = 10;
    typedef struct packed {
        logic signed [15:0] left;
        logic signed [15:0] right;
    } stereo_t;
endpackage

// File: rtl/dp_ram_stereo.sv
// dp_ram_stereo: simple dual-port stereo RAM with a registered read port.
module dp_ram_stereo
    import smpl_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  stereo_t           wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output stereo_t           rdata
);
    stereo_t mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    // Read register holds its value while re is low.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) rdata <= '0;
        else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/smpl_seq_queue.sv
// smpl_seq_queue: stereo circular sample queue replaying the last TAPS samples per new sample.
// Define SMPL_SEQ_QUEUE_OVR_EN to enable the overrun pulse on dropped writes.
module smpl_seq_queue
    import smpl_seq_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wrt_smpl,
    input  logic signed [15:0] lft_smpl,
    input  logic signed [15:0] rght_smpl,
    output logic               sequencing,
    output logic signed [15:0] lft_out,
    output logic signed [15:0] rght_out,
    output logic               overrun
);
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] T_LAST = ADDR_W'(TAPS);
    localparam logic [ADDR_W-1:0] T_M1   = ADDR_W'(TAPS - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] new_ptr, old_ptr, count, n;
    logic              we, re;
    stereo_t           rdata;

    always_comb begin
        state_nx = state;
        we       = 1'b0;
        re       = 1'b0;
        unique case (state)
            FILL: if (wrt_smpl) begin
                we = 1'b1;
                if (count == T_M1) state_nx = SEQ;
            end
            WAIT: if (wrt_smpl) begin
                we       = 1'b1;
                state_nx = SEQ;
            end
            SEQ: begin
                // n = TAPS is the trailing cycle where the last read lands.
                re = (n != T_LAST);
                if (n == T_LAST) state_nx = WAIT;
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= FILL;
            sequencing <= 1'b0;
            new_ptr    <= '0;
            old_ptr    <= '0;
            count      <= '0;
            n          <= '0;
        end else begin
            state      <= state_nx;
            sequencing <= (state_nx == SEQ);
            if (we) new_ptr <= new_ptr + ONE;
            if (we && state == WAIT) old_ptr <= old_ptr + ONE;
            if (we && state == FILL) count <= count + ONE;
            n <= (state == SEQ && state_nx == SEQ) ? n + ONE : '0;
        end

`ifdef SMPL_SEQ_QUEUE_OVR_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) overrun <= 1'b0;
        else overrun <= (state == SEQ) && wrt_smpl;
`else
    assign overrun = 1'b0;
`endif

    dp_ram_stereo #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (new_ptr),
        .wdata ({lft_smpl, rght_smpl}),
        .re    (re),
        .raddr (old_ptr + n),
        .rdata (rdata)
    );

    assign lft_out  = rdata.left;
    assign rght_out = rdata.right;
endmodule
